serial_shift_rx: RTL and testbench
==================================

SERIAL_SHIFT_RX -- requirements
Module: serial_shift_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the frame length in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2 (minimum 2), giving the synchronizer depth for all serial inputs.
REQ-003 Port clk, input, 1 bit: system clock; all state is updated on its rising edge.
REQ-004 Port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port sclk_in, input, 1 bit: serial shift clock from the remote transmitter; asynchronous to clk.
REQ-006 Port sdo_in, input, 1 bit: serial data, MSB first.
REQ-007 Port pen_in, input, 1 bit: parallel-load enable; a rising edge ends the frame.
REQ-008 Port clr_in, input, 1 bit: active-low clear from the transmitter.
REQ-009 Port pdata, output, WIDTH bits: last accepted frame.
REQ-010 Port frame_valid, output, 1 bit: single-cycle pulse when pdata is updated.
REQ-011 Port frame_err, output, 1 bit: sticky error flag, set by a bad-length frame.
REQ-012 Port busy, output, 1 bit: high while at least one bit has been shifted since the last latch or clear.

Function
REQ-013 sclk_in, sdo_in, pen_in and clr_in SHALL each pass through SYNC_STAGES flops, followed by one previous-value flop used for edge detection.
REQ-014 A pin change first sampled at clk edge k SHALL take effect on registered state and outputs at edge k+SYNC_STAGES.
REQ-015 On a synchronized sclk rising edge, the shift register SHALL load {shreg[WIDTH-2:0], sdo_sync}, using the sdo value sampled in the same synchronized cycle.
REQ-016 On a synchronized sclk rising edge, bit_cnt SHALL increment, saturating at WIDTH+1; bit_cnt width is clog2(WIDTH+2).
REQ-017 FSM state IDLE: bit_cnt=0, busy=0; an sclk rise moves to SHIFT.
REQ-018 FSM state SHIFT: 0<bit_cnt<WIDTH; reaching bit_cnt==WIDTH moves to FULL.
REQ-019 FSM state FULL: bit_cnt==WIDTH; a further sclk rise moves to OVERRUN.
REQ-020 FSM state OVERRUN: bit_cnt==WIDTH+1; stays in OVERRUN on further sclk rises.
REQ-021 Synchronized pen rise in FULL: pdata<=shreg, frame_valid=1 for exactly one cycle, frame_err<=0, then go to IDLE.
REQ-022 Synchronized pen rise in IDLE, SHIFT or OVERRUN: pdata unchanged, frame_valid stays 0, frame_err<=1, then go to IDLE.
REQ-023 sclk rise and pen rise in the same synchronized cycle: the shift and count SHALL apply first, and the latch decision SHALL use the post-shift count and data.
REQ-024 While the synchronized clr is low: shreg=0, bit_cnt=0, pdata=0, frame_err=0, state=IDLE, frame_valid=0, and sclk/pen edges are ignored; clr has priority over all other events.
REQ-025 The transmitter SHALL hold each of sclk high, sclk low and pen high for at least SYNC_STAGES+1 clk cycles, and SHALL hold sdo stable for SYNC_STAGES+1 cycles before and after each sclk rise; narrower pulses may be missed, and the block need not detect this.
REQ-026 busy SHALL be 1 in SHIFT, FULL and OVERRUN, and 0 in IDLE.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 rstn low SHALL asynchronously force pdata=0, frame_valid=0, frame_err=0, busy=0, shreg=0, bit_cnt=0, state=IDLE.
REQ-029 rstn low SHALL asynchronously force all synchronizer and edge flops to sclk=0, pen=0, clr=1, sdo=0.
REQ-030 A reset asserted mid-frame SHALL discard the partial frame, and the first full frame after release SHALL be accepted normally.
REQ-031 Reset release SHALL be synchronous to clk, and no edge SHALL be detected in the first cycle after release.

Verification
REQ-032 Send 16 bits of 0xA5C3 MSB first, then pulse pen -> pdata=16'hA5C3, one frame_valid pulse, frame_err=0, busy=0 afterwards.
REQ-033 Send 15 bits, then pulse pen -> pdata keeps its previous value, frame_valid stays 0, frame_err=1; a following good 0x1234 frame -> pdata=16'h1234 and frame_err=0.
REQ-034 Send 17 bits, then pulse pen -> state OVERRUN before the latch, frame_err=1, pdata unchanged.
REQ-035 Send 8 bits, then drive clr low for 4 cycles, then send a full 0xFFFF frame -> pdata=0 during clr, then 16'hFFFF, with no error.
REQ-036 Send 15 bits, then raise the 16th sclk and pen at the same edge with sdo=1 -> frame accepted, pdata[0]=1, frame_valid pulses once.
REQ-037 Assert rstn low after 10 bits of a frame, release, then send 0x00F0 -> all outputs are 0 during reset, then pdata=16'h00F0 and frame_valid pulses.

Source files
------------

// File: rtl/serial_shift_rx.sv
// Serial-to-parallel frame receiver: synchronizes an asynchronous shift clock,
// data, load-enable and clear, and latches WIDTH-bit frames on pen rising edges.
module serial_shift_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sclk_in,
    input  logic             sdo_in,
    input  logic             pen_in,
    input  logic             clr_in,
    output logic [WIDTH-1:0] pdata,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(WIDTH + 1);
    // Pin vector order {sdo, clr, pen, sclk}; clr idles high.
    localparam logic [3:0] PIN_RST = 4'b0100;

    typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVERRUN} state_t;

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  pins_s;
    logic                        sclk_prev_q, pen_prev_q;
    logic                        sclk_rise, pen_rise;

    state_t           state_q, state_d, state_post;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             fv_q, fv_d, err_q, err_d, busy_q, busy_d;

    assign pins_s    = sync_q[SYNC_STAGES-1];
    assign sclk_rise = pins_s[0] & ~sclk_prev_q;
    assign pen_rise  = pins_s[1] & ~pen_prev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q      <= {SYNC_STAGES{PIN_RST}};
            sclk_prev_q <= 1'b0;
            pen_prev_q  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], {sdo_in, clr_in, pen_in, sclk_in}};
            sclk_prev_q <= pins_s[0];
            pen_prev_q  <= pins_s[1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            pdata_q <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            pdata_q <= pdata_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Shift/count first, then the pen decision sees the post-shift state.
    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        pdata_d    = pdata_q;
        err_d      = err_q;
        fv_d       = 1'b0;
        state_post = state_q;

        if (sclk_rise) begin
            shreg_d = {shreg_q[WIDTH-2:0], pins_s[3]};
            if (cnt_q != CNT_OVR) cnt_d = cnt_q + 1'b1;
            case (state_q)
                IDLE, SHIFT: state_post = (cnt_d == CNT_FULL) ? FULL : SHIFT;
                default:     state_post = OVERRUN;
            endcase
        end

        state_d = state_post;
        if (pen_rise) begin
            if (state_post == FULL) begin
                pdata_d = shreg_d;
                fv_d    = 1'b1;
                err_d   = 1'b0;
            end else begin
                err_d   = 1'b1;
            end
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end

        if (!pins_s[2]) begin
            shreg_d = '0;
            cnt_d   = '0;
            pdata_d = '0;
            err_d   = 1'b0;
            fv_d    = 1'b0;
            state_d = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    assign pdata       = pdata_q;
    assign frame_valid = fv_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_serial_shift_rx.sv
// Directed bench for serial_shift_rx: frames drive a scoreboard of expected
// pdata values that a monitor pops on each frame_valid pulse.
module tb_serial_shift_rx;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rstn, sclk_in, sdo_in, pen_in, clr_in;
    logic [WIDTH-1:0] pdata;
    logic             frame_valid, frame_err, busy;

    int               n_assert = 0;
    int               n_fail   = 0;
    int               n_fv     = 0;
    logic             fv_prev  = 1'b0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_v;

    serial_shift_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .sclk_in(sclk_in), .sdo_in(sdo_in),
        .pen_in(pen_in), .clr_in(clr_in), .pdata(pdata),
        .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Scoreboard monitor: every pulse must match a queued frame and last one cycle.
    always @(negedge clk) begin
        if (rstn && frame_valid) begin
            n_fv++;
            n_assert++;
            assert (!fv_prev) else begin
                n_fail++;
                $error("FAIL fv_single: observed %0d expected %0d", fv_prev, 0);
            end
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $error("FAIL fv_unexpected: observed pdata %h expected no pulse", pdata);
            end else begin
                exp_v = sb.pop_front();
                assert (pdata === exp_v) else begin
                    n_fail++;
                    $error("FAIL sb_pdata: observed %h expected %h", pdata, exp_v);
                end
            end
        end
        fv_prev <= frame_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdo_in = b;  cyc(4);
        sclk_in = 1'b1; cyc(4);
        sclk_in = 1'b0; cyc(4);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pulse_pen();
        pen_in = 1'b1; cyc(4);
        pen_in = 1'b0; cyc(6);
    endtask

    initial begin
        rstn = 1'b0; sclk_in = 1'b0; sdo_in = 1'b0; pen_in = 1'b0; clr_in = 1'b1;
        cyc(3);
        check("rst_pdata", 32'(pdata), 0);
        check("rst_fv",    32'(frame_valid), 0);
        check("rst_err",   32'(frame_err), 0);
        check("rst_busy",  32'(busy), 0);
        rstn = 1'b1;
        cyc(3);

        // Good frame
        send_bits(32'hA5C3, 16);
        check("a5c3_busy_pre", 32'(busy), 1);
        sb.push_back(16'hA5C3);
        pulse_pen();
        check("a5c3_pdata", 32'(pdata), 32'hA5C3);
        check("a5c3_err",   32'(frame_err), 0);
        check("a5c3_busy",  32'(busy), 0);

        // Short frame, then recovery
        send_bits(32'h7FFF, 15);
        pulse_pen();
        check("short_err",   32'(frame_err), 1);
        check("short_pdata", 32'(pdata), 32'hA5C3);
        check("short_busy",  32'(busy), 0);
        send_bits(32'h1234, 16);
        sb.push_back(16'h1234);
        pulse_pen();
        check("1234_pdata", 32'(pdata), 32'h1234);
        check("1234_err",   32'(frame_err), 0);

        // Overrun
        send_bits(32'h1FFFF, 17);
        check("ovr_cnt",  32'(dut.cnt_q), 17);
        check("ovr_busy", 32'(busy), 1);
        pulse_pen();
        check("ovr_err",   32'(frame_err), 1);
        check("ovr_pdata", 32'(pdata), 32'h1234);

        // Clear mid-frame
        send_bits(32'hAB, 8);
        clr_in = 1'b0; cyc(4);
        check("clr_pdata", 32'(pdata), 0);
        check("clr_err",   32'(frame_err), 0);
        check("clr_busy",  32'(busy), 0);
        clr_in = 1'b1; cyc(4);
        send_bits(32'hFFFF, 16);
        sb.push_back(16'hFFFF);
        pulse_pen();
        check("ffff_pdata", 32'(pdata), 32'hFFFF);
        check("ffff_err",   32'(frame_err), 0);

        // Last sclk rise and pen rise together
        send_bits(32'h6B2D >> 1, 15);
        sdo_in = 1'b1; cyc(4);
        sb.push_back(16'h6B2D);
        sclk_in = 1'b1; pen_in = 1'b1; cyc(4);
        sclk_in = 1'b0; pen_in = 1'b0; cyc(6);
        check("same_pdata", 32'(pdata), 32'h6B2D);
        check("same_bit0",  32'(pdata[0]), 1);
        check("same_err",   32'(frame_err), 0);
        check("same_busy",  32'(busy), 0);

        // Reset mid-frame
        send_bits(32'h3FF, 10);
        rstn = 1'b0; cyc(2);
        check("mrst_pdata", 32'(pdata), 0);
        check("mrst_fv",    32'(frame_valid), 0);
        check("mrst_err",   32'(frame_err), 0);
        check("mrst_busy",  32'(busy), 0);
        rstn = 1'b1; cyc(3);
        send_bits(32'h00F0, 16);
        sb.push_back(16'h00F0);
        pulse_pen();
        check("00f0_pdata", 32'(pdata), 32'h00F0);
        check("00f0_err",   32'(frame_err), 0);

        cyc(4);
        check("sb_empty", 32'(sb.size()), 0);
        check("fv_count", 32'(n_fv), 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
